button_press: RTL and testbench
===============================

BUTTON_PRESS -- requirements
Module: button_press

Interface
REQ-001 Parameter TICK_MAX, default 17'd100_000, sets clock cycles per 1 ms tick; the legal range is 1..131071.
REQ-002 Parameter LONG_MS, default 11'd1000, sets the hold time in ms before long_press fires; the legal range is 2..2047.
REQ-003 Parameter REPEAT_MS, default 11'd200, sets the auto-repeat period in ms; the legal range is 1..2047.
REQ-004 Port ck, input, 1 bit, is the single system clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n, input, 1 bit, is an asynchronous active-low reset.
REQ-006 Port button_deb, input, 1 bit, is the debounced button level, synchronous to ck (debounce output).
REQ-007 Port press, output, 1 bit, SHALL be a one-cycle pulse on each new press.
REQ-008 Port long_press, output, 1 bit, SHALL be a one-cycle pulse when the hold reaches LONG_MS.
REQ-009 Port repeat, output, 1 bit, SHALL be a one-cycle auto-repeat pulse while the button is held past long_press.
REQ-010 Port held, output, 1 bit, SHALL be a level, high whenever state != IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, PRESSED and HELD, encoded in 2 bits; an unused encoding SHALL go to IDLE on the next edge.
REQ-012 IDLE -> PRESSED SHALL occur on an edge where button_deb=1 and the prior sample btn_q=0; press SHALL be high for the cycle after that edge.
REQ-013 PRESSED -> HELD SHALL occur when the ms counter reaches LONG_MS-1 together with a tick; long_press SHALL be high for the following cycle, exactly LONG_MS*TICK_MAX cycles after the press high cycle.
REQ-014 In HELD, repeat SHALL pulse every REPEAT_MS*TICK_MAX cycles, with the first pulse REPEAT_MS*TICK_MAX cycles after the long_press high cycle.
REQ-015 button_deb=0 sampled in PRESSED or HELD SHALL return the FSM to IDLE on that edge, clear both counters and suppress any pulse due on that edge; release SHALL win over a simultaneous tick.
REQ-016 The prescaler (17 bits) SHALL count 0..TICK_MAX-1 and wrap; tick SHALL be high at TICK_MAX-1; the prescaler SHALL be held at 0 in IDLE.
REQ-017 The ms counter (11 bits) SHALL clear on entry to PRESSED and on entry to HELD, and on each repeat pulse; it SHALL increment on tick and never wrap through its width.
REQ-018 press, long_press and repeat SHALL be registered outputs; at most one of them SHALL be high in any cycle.
REQ-019 A new press SHALL require button_deb to be sampled 0 first, so a held button produces no second press.

Reset
REQ-020 While rst_n=0, press, long_press and repeat SHALL be 0, held SHALL be 0, state SHALL be IDLE and both counters SHALL be 0.
REQ-021 btn_q SHALL reset to 1, so a button held across reset release yields no press until it is released and pressed again.
REQ-022 Asserting reset mid-PRESSED or mid-HELD SHALL abort immediately with no pulse.

Configuration
REQ-023 With macro BUTTON_REPEAT_EN defined, HELD SHALL generate repeat pulses per REQ-014.
REQ-024 Without BUTTON_REPEAT_EN, repeat SHALL be tied to 0, no repeat logic SHALL be present, and HELD SHALL wait only for release.

Verification (TICK_MAX=4, LONG_MS=5, REPEAT_MS=3)
REQ-025 Short press: button_deb high for 10 cycles, then low -> press at cycle +1 only; no long_press; held high for 10 cycles.
REQ-026 Long hold with BUTTON_REPEAT_EN: button_deb high for 60 cycles -> press at cycle 1, long_press at cycle 21, repeat at cycles 33 and 45 and 57.
REQ-027 Same stimulus as REQ-026 without BUTTON_REPEAT_EN -> press at cycle 1, long_press at cycle 21, repeat never high.
REQ-028 Release coincident with the terminal tick of the long count -> no long_press; held low on the next cycle.
REQ-029 button_deb held high through reset release -> no press; after a low-then-high sequence, press fires once.
REQ-030 Reset asserted mid-HELD -> all outputs 0 asynchronously; no pulse after release of reset while the button stays high.

Source files
------------

// File: rtl/button_press.sv
// -----------------------------------------------------------------------------
// button_press
//
// Purpose:
//   Turns a debounced button level into user-interface events: a one-cycle
//   press pulse on each new press, a one-cycle long_press pulse once the
//   button has been held for LONG_MS milliseconds, and optionally a one-cycle
//   auto-repeat pulse every REPEAT_MS milliseconds while the hold continues.
//   A 1 ms time base is derived from the system clock by a prescaler that
//   only runs while the button is down.
//
// Parameters:
//   TICK_MAX  - clock cycles per 1 ms tick (1..131071)
//   LONG_MS   - hold time in ms before long_press fires (2..2047)
//   REPEAT_MS - auto-repeat period in ms (1..2047)
//
// Ports:
//   ck           in   single system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   button_deb   in   debounced button level, synchronous to ck
//   press        out  one-cycle pulse on each new press (registered)
//   long_press   out  one-cycle pulse when the hold reaches LONG_MS (registered)
//   repeat_pulse out  one-cycle auto-repeat pulse while held past long_press
//                     (registered); this is the "repeat" output, renamed
//                     because repeat is a SystemVerilog keyword
//   held         out  level, high whenever the FSM is not in IDLE
//
// Configuration:
//   BUTTON_REPEAT_EN - when defined, the HELD state produces auto-repeat
//                      pulses. When undefined, repeat_pulse is tied to 0, no
//                      repeat logic is built, and HELD just waits for release.
// -----------------------------------------------------------------------------

module button_press #(
    parameter logic [16:0] TICK_MAX  = 17'd100_000,
    parameter logic [10:0] LONG_MS   = 11'd1000,
    parameter logic [10:0] REPEAT_MS = 11'd200
) (
    input  logic ck,
    input  logic rst_n,
    input  logic button_deb,
    output logic press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Two-bit state encoding; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Previous button sample, used for rising-edge detection in IDLE.
    logic        btn_q;
    logic        btn_d;

    // 1 ms prescaler and millisecond counter.
    logic [16:0] presc_q;
    logic [16:0] presc_d;
    logic [10:0] ms_q;
    logic [10:0] ms_d;

    // Registered event pulses.
    logic        press_q;
    logic        press_d;
    logic        long_q;
    logic        long_d;

    logic        tick;
    logic [10:0] ms_inc;

`ifdef BUTTON_REPEAT_EN
    logic        rep_q;
    logic        rep_d;
`endif

    // The prescaler sits at 0 in IDLE, so the first tick of a hold lands
    // exactly TICK_MAX cycles after the press pulse cycle.
    assign tick = (presc_q == (TICK_MAX - 17'd1));

    // The ms counter saturates at its maximum instead of wrapping to 0.
    assign ms_inc = (ms_q == 11'h7FF) ? ms_q : (ms_q + 11'd1);

    // Next-state, counter and pulse logic. Release is checked before the
    // tick in every active state, so a release on the same edge as a
    // terminal tick returns to IDLE and swallows the pulse that was due.
    always_comb begin
        state_d = state_q;
        btn_d   = button_deb;
        presc_d = presc_q;
        ms_d    = ms_q;
        press_d = 1'b0;
        long_d  = 1'b0;
`ifdef BUTTON_REPEAT_EN
        rep_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                presc_d = 17'd0;
                ms_d    = 11'd0;
                // btn_q resets to 1, so a button already down at reset
                // release must be seen low before it can start a press.
                if (button_deb && !btn_q) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end

            PRESSED: begin
                if (!button_deb) begin
                    state_d = IDLE;
                    presc_d = 17'd0;
                    ms_d    = 11'd0;
                end else begin
                    presc_d = tick ? 17'd0 : (presc_q + 17'd1);
                    if (tick) begin
                        if (ms_q == (LONG_MS - 11'd1)) begin
                            state_d = HELD;
                            long_d  = 1'b1;
                            ms_d    = 11'd0;
                        end else begin
                            ms_d = ms_inc;
                        end
                    end
                end
            end

            HELD: begin
                if (!button_deb) begin
                    state_d = IDLE;
                    presc_d = 17'd0;
                    ms_d    = 11'd0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    // The prescaler keeps its phase across the PRESSED to
                    // HELD transition, so the first repeat comes a full
                    // REPEAT_MS after the long_press pulse cycle.
                    presc_d = tick ? 17'd0 : (presc_q + 17'd1);
                    if (tick) begin
                        if (ms_q == (REPEAT_MS - 11'd1)) begin
                            rep_d = 1'b1;
                            ms_d  = 11'd0;
                        end else begin
                            ms_d = ms_inc;
                        end
                    end
`else
                    // Without auto-repeat there is nothing to time here.
                    presc_d = 17'd0;
                    ms_d    = 11'd0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                presc_d = 17'd0;
                ms_d    = 11'd0;
            end
        endcase
    end

    // State, counters and pulse registers. Reset clears everything at once,
    // aborting any hold in progress without producing a pulse.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            btn_q   <= 1'b1;
            presc_q <= 17'd0;
            ms_q    <= 11'd0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            press_q <= press_d;
            long_q  <= long_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    // Auto-repeat pulse register, only present when repeat is enabled.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press      = press_q;
    assign long_press = long_q;
    assign held       = (state_q != IDLE);

endmodule

// File: tb/tb_button_press.sv
// -----------------------------------------------------------------------------
// tb_button_press
//
// Exercises button_press with TICK_MAX=4, LONG_MS=5, REPEAT_MS=3: a short
// press from a table of vectors, then hand-written sequences for the long
// hold with auto-repeat, release on the terminal tick, button held through
// reset release, and reset asserted in the middle of a hold. Repeat
// expectations follow BUTTON_REPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------

module tb_button_press;

    localparam logic [16:0] TICK_MAX  = 17'd4;
    localparam logic [10:0] LONG_MS   = 11'd5;
    localparam logic [10:0] REPEAT_MS = 11'd3;

`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic ck = 1'b0;
    logic rst_n;
    logic button_deb;
    logic press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic btn;
        logic exp_press;
        logic exp_long;
        logic exp_rep;
        logic exp_held;
    } vec_t;

    vec_t vecs [13];

    button_press #(
        .TICK_MAX  (TICK_MAX),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .ck           (ck),
        .rst_n        (rst_n),
        .button_deb   (button_deb),
        .press        (press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    // 10 ns clock period.
    always #5 ck = ~ck;

    // Drive the button on the falling edge, then step past the next rising
    // edge so the registered outputs can be sampled.
    task automatic applyStimulus(input logic btn);
        @(negedge ck);
        button_deb = btn;
        @(posedge ck);
        #1;
    endtask

    // Compare all four outputs against expected values as one check.
    task automatic checkOutput(input string name, input logic ep, input logic el,
                               input logic er, input logic eh);
        checks++;
        if (press !== ep || long_press !== el || repeat_pulse !== er || held !== eh) begin
            failures++;
            $display("[TB] FAIL %s: got press=%b long=%b rep=%b held=%b, expected press=%b long=%b rep=%b held=%b",
                     name, press, long_press, repeat_pulse, held, ep, el, er, eh);
        end
    endtask

    initial begin
        // Short press: one low sample, ten high samples, then release.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 10; i++) begin
            vecs[i] = '{1'b1, (i == 1), 1'b0, 1'b0, 1'b1};
        end
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        rst_n      = 1'b0;
        button_deb = 1'b0;
        #1;
        checkOutput("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge ck);
        #1;
        checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge ck);
        rst_n = 1'b1;

        // Table-driven short press.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].btn);
            checkOutput($sformatf("short_vec%0d", i), vecs[i].exp_press,
                        vecs[i].exp_long, vecs[i].exp_rep, vecs[i].exp_held);
        end

        // Long hold for 60 cycles: press at 1, long_press at 21, repeats at
        // 33, 45 and 57 when enabled.
        for (int k = 0; k < 60; k++) begin
            int c;
            c = k + 1;
            applyStimulus(1'b1);
            checkOutput($sformatf("long_hold_c%0d", c), (c == 1), (c == 21),
                        REP_EN && (c == 33 || c == 45 || c == 57), 1'b1);
        end
        applyStimulus(1'b0);
        checkOutput("long_release", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0);
        checkOutput("long_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Release sampled on the same edge as the terminal tick of the
        // long count: no long_press, held drops immediately.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("term_c%0d", k + 1), (k == 0), 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0);
        checkOutput("term_release", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0);
        checkOutput("term_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Button held through reset release: no press until low then high.
        @(negedge ck);
        button_deb = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_btn_high", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("post_rst_held_c%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0);
        checkOutput("post_rst_low", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1);
        checkOutput("post_rst_press", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 2; c <= 24; c++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("rehold_c%0d", c), 1'b0, (c == 21), 1'b0, 1'b1);
        end

        // Reset asserted mid-HELD: outputs clear without waiting for a clock,
        // and nothing fires afterwards while the button stays down.
        @(negedge ck);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge ck);
        #1;
        checkOutput("rst_mid_held_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge ck);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("after_rst_c%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
